// File: rtl/ex_operand_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_fwd_pkg
// Brief    : Shared widths, stage indices and in-flight entry field layout
//            for the EX operand forwarding block.
// Revision : 1.0 - initial release
// ============================================================================
package ex_operand_fwd_pkg;

    localparam int c_def_data_w = 32;
    localparam int c_def_reg_aw = 5;

    // In-flight entry layout: {dest, is_load, we, valid}, dest on top so the
    // entry width follows REG_AW.
    localparam int c_ent_valid    = 0;
    localparam int c_ent_we       = 1;
    localparam int c_ent_load     = 2;
    localparam int c_ent_dest_lsb = 3;
    localparam int c_ent_meta_w   = 3;

    localparam int c_num_stages = 3;
    localparam int c_stage_ex   = 0;
    localparam int c_stage_mem  = 1;
    localparam int c_stage_wb   = 2;

endpackage : ex_operand_fwd_pkg
`default_nettype wire

// File: rtl/ex_operand_fwd_fwd_src_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_sel
// Brief    : Per-operand producer match and EX > MEM > WB > regfile select.
//            FWD_WB_BYPASS_EN: when defined, WB matches forward wb_result;
//            otherwise a WB match stalls until the producer retires.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_sel
    import ex_operand_fwd_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int REG_AW = c_def_reg_aw
) (
    input  logic                                          i_rd,
    input  logic [REG_AW-1:0]                             i_src,
    input  logic [c_num_stages-1:0][REG_AW+c_ent_meta_w-1:0] i_ents,
    input  logic [c_num_stages-1:0][DATA_W-1:0]           i_results,
    input  logic                                          i_mem_result_valid,
    input  logic [DATA_W-1:0]                             i_rf_data,
    output logic [DATA_W-1:0]                             o_data,
    output logic                                          o_stall
);

`ifdef FWD_WB_BYPASS_EN
    localparam logic c_wb_fwd = 1'b1;
`else
    localparam logic c_wb_fwd = 1'b0;
`endif

    logic [c_num_stages-1:0] w_match;
    logic [c_num_stages-1:0] w_pend;
    logic [c_num_stages-1:0] w_ld_avail;
    logic [c_num_stages-1:0] w_fwd_ok;
    logic                    w_src_nz;
    logic                    w_pend_sel;

    // Load data is never ready in EX, ready in MEM once flagged, always in WB.
    assign w_ld_avail = {1'b1, i_mem_result_valid, 1'b0};
    assign w_fwd_ok   = {c_wb_fwd, 1'b1, 1'b1};
    assign w_src_nz   = |i_src;

    for (genvar s = 0; s < c_num_stages; s++) begin : g_stage
        logic [REG_AW-1:0] w_dest;
        assign w_dest     = i_ents[s][c_ent_dest_lsb +: REG_AW];
        assign w_match[s] = i_ents[s][c_ent_valid] & i_ents[s][c_ent_we]
                          & (w_dest == i_src) & w_src_nz;
        assign w_pend[s]  = (i_ents[s][c_ent_load] & ~w_ld_avail[s]) | ~w_fwd_ok[s];
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        o_data     = i_rf_data;
        w_pend_sel = 1'b0;
        for (int s = c_num_stages - 1; s >= 0; s--) begin
            if (w_match[s]) begin
                o_data     = i_results[s];
                w_pend_sel = w_pend[s];
            end
        end
    end

    assign o_stall = i_rd & w_pend_sel;

endmodule : fwd_src_sel
`default_nettype wire

// File: rtl/ex_operand_fwd.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_fwd
// Brief    : EX/MEM/WB destination tracking, operand forwarding and load-use
//            stall for the ID->EX boundary. Macro: FWD_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_fwd
    import ex_operand_fwd_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int REG_AW = c_def_reg_aw
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_rj_rd,
    input  logic              id_rk_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rj,
    input  logic [REG_AW-1:0] id_rk,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [DATA_W-1:0] rf_rj_data,
    input  logic [DATA_W-1:0] rf_rk_data,
    input  logic              adv,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              mem_result_valid,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] rj_from_fwd,
    output logic [DATA_W-1:0] rk_from_fwd
);

    localparam int ENT_W = REG_AW + c_ent_meta_w;

    logic [ENT_W-1:0]                       r_ex_ent;
    logic [ENT_W-1:0]                       r_mem_ent;
    logic [ENT_W-1:0]                       r_wb_ent;
    logic [DATA_W-1:0]                      r_rj;
    logic [DATA_W-1:0]                      r_rk;
    logic [ENT_W-1:0]                       w_id_ent;
    logic [c_num_stages-1:0][ENT_W-1:0]     w_ents;
    logic [c_num_stages-1:0][DATA_W-1:0]    w_results;
    logic [DATA_W-1:0]                      w_rj_sel;
    logic [DATA_W-1:0]                      w_rk_sel;
    logic                                   w_stall_rj;
    logic                                   w_stall_rk;
    logic                                   w_issue;

    assign w_ents    = {r_wb_ent, r_mem_ent, r_ex_ent};
    assign w_results = {wb_result, mem_result, ex_result};

    always_comb begin
        w_id_ent                            = '0;
        w_id_ent[c_ent_valid]               = 1'b1;
        w_id_ent[c_ent_we]                  = id_we;
        w_id_ent[c_ent_load]                = id_is_load;
        w_id_ent[c_ent_dest_lsb +: REG_AW]  = id_dest;
    end

    fwd_src_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_sel_rj (
        .i_rd               (id_rj_rd),
        .i_src              (id_rj),
        .i_ents             (w_ents),
        .i_results          (w_results),
        .i_mem_result_valid (mem_result_valid),
        .i_rf_data          (rf_rj_data),
        .o_data             (w_rj_sel),
        .o_stall            (w_stall_rj)
    );

    fwd_src_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_sel_rk (
        .i_rd               (id_rk_rd),
        .i_src              (id_rk),
        .i_ents             (w_ents),
        .i_results          (w_results),
        .i_mem_result_valid (mem_result_valid),
        .i_rf_data          (rf_rk_data),
        .o_data             (w_rk_sel),
        .o_stall            (w_stall_rk)
    );

    assign id_stall = id_valid & (w_stall_rj | w_stall_rk);
    assign w_issue  = id_valid & ~id_stall & ~flush;

    // Flush only kills what enters EX; older stages keep retiring on adv.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ent  <= '0;
            r_mem_ent <= '0;
            r_wb_ent  <= '0;
            r_rj      <= '0;
            r_rk      <= '0;
        end else begin
            if (adv) begin
                r_wb_ent  <= r_mem_ent;
                r_mem_ent <= r_ex_ent;
            end
            if (flush) begin
                r_ex_ent <= '0;
            end else if (adv) begin
                r_ex_ent <= w_issue ? w_id_ent : '0;
            end
            if (adv && w_issue) begin
                r_rj <= w_rj_sel;
                r_rk <= w_rk_sel;
            end
        end
    end

    assign ex_valid    = r_ex_ent[c_ent_valid];
    assign rj_from_fwd = r_rj;
    assign rk_from_fwd = r_rk;

endmodule : ex_operand_fwd
`default_nettype wire

// File: tb/tb_ex_operand_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_fwd
// Brief    : Randomized + directed scoreboard bench for ex_operand_fwd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_fwd;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef FWD_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_rj_rd, id_rk_rd, id_we, id_is_load;
    logic [AW-1:0] id_rj, id_rk, id_dest;
    logic [DW-1:0] rf_rj_data, rf_rk_data;
    logic          adv, flush;
    logic [DW-1:0] ex_result, mem_result, wb_result;
    logic          mem_result_valid;
    logic          id_stall, ex_valid;
    logic [DW-1:0] rj_from_fwd, rk_from_fwd;

    always #5 clk = ~clk;

    ex_operand_fwd #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rj_rd(id_rj_rd), .id_rk_rd(id_rk_rd),
        .id_we(id_we), .id_is_load(id_is_load),
        .id_rj(id_rj), .id_rk(id_rk), .id_dest(id_dest),
        .rf_rj_data(rf_rj_data), .rf_rk_data(rf_rk_data),
        .adv(adv), .flush(flush),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .mem_result_valid(mem_result_valid),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .rj_from_fwd(rj_from_fwd), .rk_from_fwd(rk_from_fwd)
    );

    // Reference model: list of in-flight instructions, youngest first.
    typedef struct { bit v; bit we; bit ld; int dest; } ent_t;
    typedef struct { bit v; logic [DW-1:0] rj; logic [DW-1:0] rk; } exp_t;

    ent_t          m_pipe [3];
    exp_t          exp_q [$];
    exp_t          mon_e;
    bit            mon_upd;
    logic [DW-1:0] m_rj, m_rk;
    logic [DW-1:0] rf [32];
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // The youngest in-flight writer of src supplies the value; it is usable
    // unless it is a load still in EX, a load in MEM without data, or (no
    // bypass) sitting in WB.
    function automatic void model_src(input int src, input logic [DW-1:0] rfv,
                                      output logic [DW-1:0] data, output bit pend);
        data = rfv;
        pend = 1'b0;
        if (src == 0) return;
        for (int s = 0; s < 3; s++) begin
            if (m_pipe[s].v && m_pipe[s].we && m_pipe[s].dest == src) begin
                if (s == 0) begin
                    data = ex_result;  pend = m_pipe[s].ld;
                end else if (s == 1) begin
                    data = mem_result; pend = m_pipe[s].ld && !mem_result_valid;
                end else begin
                    data = wb_result;  pend = !WB_BYPASS;
                end
                return;
            end
        end
    endfunction

    task automatic model_eval();
        logic [DW-1:0] dj, dk;
        bit pj, pk, stall, issue;
        model_src(int'(id_rj), rf_rj_data, dj, pj);
        model_src(int'(id_rk), rf_rk_data, dk, pk);
        stall = id_valid && ((id_rj_rd && pj) || (id_rk_rd && pk));
        check("id_stall", {31'd0, id_stall}, {31'd0, stall});
        issue = adv && id_valid && !stall && !flush;
        if (adv || flush) begin
            if (issue) begin
                m_rj = dj;
                m_rk = dk;
            end
            exp_q.push_back('{issue, m_rj, m_rk});
        end
        if (adv) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = issue ? '{1'b1, id_we, id_is_load, int'(id_dest)} : '{1'b0, 1'b0, 1'b0, 0};
        end
        if (flush) m_pipe[0] = '{1'b0, 1'b0, 1'b0, 0};
    endtask

    task automatic step(input bit iv, input bit rjr, input bit rkr, input bit we, input bit ld,
                        input int rj, input int rk, input int dest,
                        input bit a, input bit f, input bit mrv,
                        input logic [DW-1:0] exr, input logic [DW-1:0] memr, input logic [DW-1:0] wbr);
        @(posedge clk); #1;
        id_valid = iv; id_rj_rd = rjr; id_rk_rd = rkr; id_we = we; id_is_load = ld;
        id_rj = 5'(rj); id_rk = 5'(rk); id_dest = 5'(dest);
        rf_rj_data = rf[rj]; rf_rk_data = rf[rk];
        adv = a; flush = f; mem_result_valid = mrv;
        ex_result = exr; mem_result = memr; wb_result = wbr;
        @(negedge clk);
        model_eval();
    endtask

    // Wait for the edge that applies the last step, then freeze the pipe.
    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic freeze();
        adv = 1'b0; flush = 1'b0;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) m_pipe[s] = '{1'b0, 1'b0, 1'b0, 0};
        m_rj = '0; m_rk = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1; #1;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_rj", rj_from_fwd, 32'd0);
        check("rst_rk", rk_from_fwd, 32'd0);
        check("rst_id_stall", {31'd0, id_stall}, 32'd0);
        clear_model();
        freeze();
        @(posedge clk); #3;
        reset = 1'b0;
    endtask

    // Monitor: every edge that moves or flushes EX yields one scoreboard entry.
    initial begin
        forever begin
            @(posedge clk);
            mon_upd = (adv || flush) && !reset;
            #2;
            if (mon_upd && !reset) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_underflow: got output update expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ex_valid", {31'd0, ex_valid}, {31'd0, mon_e.v});
                    check("rj_from_fwd", rj_from_fwd, mon_e.rj);
                    check("rk_from_fwd", rk_from_fwd, mon_e.rk);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rj_rd = 0; id_rk_rd = 0; id_we = 0; id_is_load = 0;
        id_rj = '0; id_rk = '0; id_dest = '0; rf_rj_data = '0; rf_rk_data = '0;
        adv = 0; flush = 0; ex_result = '0; mem_result = '0; wb_result = '0;
        mem_result_valid = 0;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        clear_model();
        #2;
        check("init_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("init_rj", rj_from_fwd, 32'd0);
        check("init_stall", {31'd0, id_stall}, 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;

        // Back-to-back: add r5, then read r5 as rk.
        step(1,0,0,1,0, 0,0,5, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(1,0,1,0,0, 0,5,0, 1,0,1, 32'h1234, 32'h0, 32'h0);
        check("b2b_stall", {31'd0, id_stall}, 32'd0);
        settle(); check("b2b_rk", rk_from_fwd, 32'h1234); freeze();

        // Load-use on r6, then MEM supplies the load data.
        step(1,0,0,1,1, 0,0,6, 1,0,0, 32'h0, 32'h0, 32'h0);
        step(1,1,0,1,0, 6,0,8, 1,0,0, 32'h0, 32'h0, 32'h0);
        check("ldu_stall", {31'd0, id_stall}, 32'd1);
        step(1,1,0,1,0, 6,0,8, 1,0,1, 32'h0, 32'hCAFE, 32'h0);
        check("ldu_release", {31'd0, id_stall}, 32'd0);
        settle(); check("ldu_rj", rj_from_fwd, 32'hCAFE); freeze();

        // EX beats MEM for r7.
        step(1,0,0,1,0, 0,0,7, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(1,0,0,1,0, 0,0,7, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(1,1,0,0,0, 7,0,0, 1,0,1, 32'h1, 32'h2, 32'h3);
        settle(); check("prio_rj", rj_from_fwd, 32'h1); freeze();

        // r0 is never forwarded.
        step(1,0,0,1,0, 0,0,0, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(1,1,1,0,0, 0,0,0, 1,0,1, 32'hFFFF, 32'h0, 32'h0);
        check("r0_stall", {31'd0, id_stall}, 32'd0);
        settle(); check("r0_rj", rj_from_fwd, 32'h0); check("r0_rk", rk_from_fwd, 32'h0); freeze();

        // WB producer of r9.
        step(1,0,0,1,0, 0,0,9, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(0,0,0,0,0, 0,0,0, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(0,0,0,0,0, 0,0,0, 1,0,1, 32'h0, 32'h0, 32'h0);
        step(1,1,0,0,0, 9,0,0, 1,0,1, 32'h0, 32'h0, 32'h55);
        check("wb_stall", {31'd0, id_stall}, {31'd0, !WB_BYPASS});
        settle(); check("wb_rj", rj_from_fwd, WB_BYPASS ? 32'h55 : m_rj); freeze();
        step(1,1,0,0,0, 9,0,0, 1,0,1, 32'h0, 32'h0, 32'h55);
        check("wb_retired_stall", {31'd0, id_stall}, 32'd0);
        settle(); check("wb_retired_rj", rj_from_fwd, rf[9]); freeze();

        // Flush wins over adv; then reset in the middle of a load-use stall.
        step(1,1,0,1,0, 3,0,3, 1,1,1, 32'h0, 32'h0, 32'h0);
        settle(); check("flush_ex_valid", {31'd0, ex_valid}, 32'd0); freeze();
        step(1,0,0,1,1, 0,0,4, 1,0,0, 32'h0, 32'h0, 32'h0);
        step(1,1,0,0,0, 4,0,0, 0,0,0, 32'h0, 32'h0, 32'h0);
        check("pre_rst_stall", {31'd0, id_stall}, 32'd1);
        do_reset();

        // Randomized traffic on a small register window for frequent hazards.
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) for (int i = 1; i < 32; i++) rf[i] = $urandom;
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 3) == 0,
                 $urandom % 8, $urandom % 8, $urandom % 8,
                 ($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 3) != 0,
                 $urandom, $urandom, $urandom);
        end
        settle(); freeze();
        @(posedge clk); #3;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ex_operand_fwd
`default_nettype wire
